// File: rtl/game_score_timer_pkg.sv
// game_pkg: round states and active-low 7-segment codes shared by the score/timer block
package game_pkg;
  typedef enum logic [1:0] {READY, PLAY, DONE} state_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_LUT [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                          SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
endpackage

// File: rtl/game_score_timer_seg7_decode.sv
// seg7_decode: one BCD digit to active-low gfedcba segments, blank for non-BCD codes
module seg7_decode
  import game_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  assign seg_o = (bcd_i > 4'd9) ? SEG_BLANK : SEG_LUT[bcd_i];
endmodule

// File: rtl/game_score_timer.sv
// game_score_timer: ready/play/done round FSM with BCD countdown, saturating BCD score and 7-seg outputs
module game_score_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int READY_SEC = 3,
  parameter int GAME_SEC  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add,
  output logic       start,
  output logic       finish,
  output logic [6:0] time1,
  output logic [6:0] time10,
  output logic [6:0] score1,
  output logic [6:0] score10
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0] RDY0 = 4'(READY_SEC);
  localparam logic [3:0] G10  = 4'(GAME_SEC / 10);
  localparam logic [3:0] G1   = 4'(GAME_SEC % 10);
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    rdy_q, rdy_d, rem10_q, rem10_d, rem1_q, rem1_d, sc10_q, sc10_d, sc1_q, sc1_d;
  logic          add_q, tick, add_edge;
  // next state: prescaler, round phase, countdown and score (ticks only happen outside DONE)
  always_comb begin
    tick     = (state_q != DONE) && (pre_q == PRE_MAX);
    add_edge = add & ~add_q;
    state_d  = state_q;
    rdy_d    = rdy_q;
    rem10_d  = rem10_q;
    rem1_d   = rem1_q;
    sc10_d   = sc10_q;
    sc1_d    = sc1_q;
    pre_d    = (tick || state_q == DONE) ? '0 : pre_q + 1'b1;
    if (tick && state_q == READY) begin
      rdy_d = rdy_q - 4'd1;
      if (rdy_q == 4'd1) state_d = PLAY;
    end
    if (tick && state_q == PLAY) begin
      if (rem10_q == 4'd0 && rem1_q == 4'd1) begin
        rem1_d  = 4'd0;
        state_d = DONE;
      end else if (rem1_q == 4'd0) begin
        rem10_d = rem10_q - 4'd1;
        rem1_d  = 4'd9;
      end else rem1_d = rem1_q - 4'd1;
    end
    if (add_edge && state_q == PLAY && !(sc10_q == 4'd9 && sc1_q == 4'd9)) begin
      sc1_d  = (sc1_q == 4'd9) ? 4'd0 : sc1_q + 4'd1;
      sc10_d = (sc1_q == 4'd9) ? sc10_q + 4'd1 : sc10_q;
    end
  end
  // state register; start/finish decoded from the next state so they move with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= READY;
      pre_q   <= '0;
      rdy_q   <= RDY0;
      rem10_q <= G10;
      rem1_q  <= G1;
      sc10_q  <= 4'd0;
      sc1_q   <= 4'd0;
      add_q   <= 1'b0;
      start   <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rdy_q   <= rdy_d;
      rem10_q <= rem10_d;
      rem1_q  <= rem1_d;
      sc10_q  <= sc10_d;
      sc1_q   <= sc1_d;
      add_q   <= add;
      start   <= state_d != READY;
      finish  <= state_d == DONE;
    end
  end
  seg7_decode u_time1   (.bcd_i(rem1_q),  .seg_o(time1));
  seg7_decode u_time10  (.bcd_i(rem10_q), .seg_o(time10));
  seg7_decode u_score1  (.bcd_i(sc1_q),   .seg_o(score1));
  seg7_decode u_score10 (.bcd_i(sc10_q),  .seg_o(score10));
endmodule

// File: tb/tb_game_score_timer.sv
// tb_game_score_timer: randomized scoreboard bench for a 12 s round and a 99 s round driven in parallel
module tb_game_score_timer;
  logic clk, reset, add0, add1;
  logic start0, finish0, start1, finish1;
  logic [6:0] t1_0, t10_0, s1_0, s10_0, t1_1, t10_1, s1_1, s10_1;
  logic [29:0] got0, got1;
  logic [29:0] q0[$], q1[$];
  int tests = 0, fails = 0;
  int n = 0;
  int sc[2] = '{0, 0};
  logic pv[2] = '{1'b0, 1'b0};
  int gs[2] = '{12, 99};

  game_score_timer #(.CLK_HZ(10), .READY_SEC(2), .GAME_SEC(12)) u_dut0 (
    .clk(clk), .reset(reset), .add(add0), .start(start0), .finish(finish0),
    .time1(t1_0), .time10(t10_0), .score1(s1_0), .score10(s10_0));
  game_score_timer #(.CLK_HZ(10), .READY_SEC(2), .GAME_SEC(99)) u_dut1 (
    .clk(clk), .reset(reset), .add(add1), .start(start1), .finish(finish1),
    .time1(t1_1), .time10(t10_1), .score1(s1_1), .score10(s10_1));

  assign got0 = {start0, finish0, t10_0, t1_0, s10_0, s1_0};
  assign got1 = {start1, finish1, t10_1, t1_1, s10_1, s1_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // expected outputs after n clocks since reset release: 2 s of READY, then a G-second round
  function automatic logic [29:0] expv(int i);
    int rem;
    rem = (n < 20) ? gs[i] : (n >= 20 + 10 * gs[i]) ? 0 : gs[i] - (n - 20) / 10;
    return {n >= 20, n >= 20 + 10 * gs[i], seg(rem / 10), seg(rem % 10), seg(sc[i] / 10), seg(sc[i] % 10)};
  endfunction

  function automatic logic a1v();
    return (n >= 20) ? n[0] : 1'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [29:0] act, input logic [29:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic a0, input logic a1);
    logic a;
    add0 = a0;
    add1 = a1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      a = i ? a1 : a0;
      if (a && !pv[i] && n >= 20 && n < 20 + 10 * gs[i]) sc[i] = (sc[i] < 99) ? sc[i] + 1 : 99;
      pv[i] = a;
    end
    n++;
    q0.push_back(expv(0));
    q1.push_back(expv(1));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    sc = '{0, 0};
    pv = '{1'b0, 1'b0};
    #1;
    chk("reset_round12", got0, expv(0));
    chk("reset_round99", got1, expv(1));
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0 && q1.size() > 0) begin
      chk("round12_outputs", got0, q0.pop_front());
      chk("round99_outputs", got1, q1.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    add0 = 1'b0;
    add1 = 1'b0;
    #1;
    do_reset();
    for (int i = 0; i < 17; i++) step(1'($urandom), a1v());
    repeat (4) step(1'b1, a1v());
    step(1'b0, a1v());
    repeat (50) step(1'b1, a1v());
    step(1'b0, a1v());
    while (n < 130) begin
      int w, g;
      w = $urandom_range(1, 3);
      g = $urandom_range(1, 4);
      repeat (w) step(1'b1, a1v());
      repeat (g) step(1'b0, a1v());
    end
    while (n < 139) step(1'b0, a1v());
    step(1'b1, a1v());
    step(1'b0, a1v());
    repeat (120) step(1'($urandom), a1v());
    do_reset();
    repeat (22) step(1'b0, a1v());
    repeat (5) begin
      step(1'b1, a1v());
      step(1'b0, a1v());
    end
    chk("mid_play_score05", {16'd0, s10_0, s1_0}, {16'd0, seg(0), seg(5)});
    do_reset();
    repeat (200) step(1'($urandom), a1v());
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 30'(q0.size() + q1.size()), 30'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
